// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared definitions for the FIFO read-side arbiter.
//   - FSM state encoding (IDLE/ISSUE/WAIT/CHECK)
//   - default sizing for requester count, ID width, data width,
//     burst limit and FIFO read latency
package fifo_arb_pkg;

  localparam int NREQ_DEF      = 4;
  localparam int IDW_DEF       = 2;
  localparam int DW_DEF        = 8;
  localparam int MAX_BURST_DEF = 4;
  localparam int BCW_DEF       = 3;
  localparam int RD_LAT_DEF    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    CHECK = 2'd3
  } arb_state_e;

endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// fifo_rd_arbiter_if: bundle of the arbiter's request, FIFO read-port and
// tagged-return signals.
//   slave  : arbiter side (consumes req/fifo_empty/fifo_rdata, drives the rest)
//   master : environment side (requesters + FIFO + data sink)
// Signals:
//   req        NREQ  level request per consumer
//   fifo_empty 1     registered FIFO empty flag
//   fifo_rdata DW    FIFO read data
//   fifo_r_en  1     FIFO read enable, one pulse per pop
//   gnt        NREQ  one-hot current owner, zero when idle
//   rd_valid   1     rd_data/rd_id valid
//   rd_data    DW    popped byte
//   rd_id      IDW   owner of the popped byte
//   busy       1     burst in progress
interface fifo_rd_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = IDW_DEF,
  parameter int DW   = DW_DEF
);
  logic [NREQ-1:0] req;
  logic            fifo_empty;
  logic [DW-1:0]   fifo_rdata;
  logic            fifo_r_en;
  logic [NREQ-1:0] gnt;
  logic            rd_valid;
  logic [DW-1:0]   rd_data;
  logic [IDW-1:0]  rd_id;
  logic            busy;

  modport slave (
    input  req, fifo_empty, fifo_rdata,
    output fifo_r_en, gnt, rd_valid, rd_data, rd_id, busy
  );

  modport master (
    output req, fifo_empty, fifo_rdata,
    input  fifo_r_en, gnt, rd_valid, rd_data, rd_id, busy
  );
endinterface

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   : request vector
//   ptr   : highest-priority index for this search
//   found : at least one request bit set
//   idx   : first set request at or after ptr, wrapping at NREQ
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            found,
  output logic [IDW-1:0]  idx
);

  logic [IDW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest set bit to ptr
  // is the last one written and therefore wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: read-side scheduler for the async FIFO (rclk domain).
// Shares the single FIFO read port among NREQ consumers with round-robin
// bursts of up to MAX_BURST pops, never popping faster than the registered
// empty flag can confirm, and returns each popped byte tagged with its owner.
// Ports:
//   rclk : read-domain clock
//   rrst : synchronous active-high reset
//   bus  : fifo_rd_arbiter_if.slave (req, fifo_empty, fifo_rdata in;
//          fifo_r_en, gnt, rd_valid, rd_data, rd_id, busy out)
module fifo_rd_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int IDW       = IDW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int BCW       = BCW_DEF,
  parameter int RD_LAT    = RD_LAT_DEF
) (
  input  logic              rclk,
  input  logic              rrst,
  fifo_rd_arbiter_if.slave  bus
);

  arb_state_e      state_q;
  logic [NREQ-1:0] gnt_q;
  logic [IDW-1:0]  owner_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  ptr_d;
  logic [BCW-1:0]  cnt_q;
  logic [BCW-1:0]  cnt_d;

  logic                     tag_vld_q [RD_LAT];
  logic [IDW-1:0]           tag_id_q  [RD_LAT];

  logic            rd_valid_q;
  logic [DW-1:0]   rd_data_q;
  logic [IDW-1:0]  rd_id_q;

  logic            pick_found;
  logic [IDW-1:0]  pick_idx;
  logic [NREQ-1:0] pick_onehot;
  logic            issue;
  logic            continue_burst;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign pick_onehot = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
  assign issue       = (state_q == ISSUE);
  assign cnt_d       = cnt_q + 1'b1;
  assign ptr_d       = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  // In CHECK the registered empty flag already accounts for the last pop,
  // so it is safe to issue another one.
  assign continue_burst = (cnt_q < BCW'(MAX_BURST)) && bus.req[owner_q] &&
                          !bus.fifo_empty;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found && !bus.fifo_empty) begin
            gnt_q   <= pick_onehot;
            owner_q <= pick_idx;
            cnt_q   <= '0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= cnt_d;
          state_q <= WAIT;
        end
        WAIT: begin
          // Gives the one-cycle-late empty flag time to see the pop.
          state_q <= CHECK;
        end
        CHECK: begin
          if (continue_burst) begin
            state_q <= ISSUE;
          end else begin
            gnt_q   <= '0;
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---- p0..p(RD_LAT-1): tag pipe, runs independently of the FSM ----
  always_ff @(posedge rclk) begin
    if (rrst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_id_q[i]  <= '0;
      end
    end else begin
      tag_vld_q[0] <= issue;
      tag_id_q[0]  <= owner_q;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  // ---- return stage: capture fifo_rdata when its tag arrives ----
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_id_q    <= '0;
    end else begin
      rd_valid_q <= tag_vld_q[RD_LAT-1];
      if (tag_vld_q[RD_LAT-1]) begin
        rd_data_q <= bus.fifo_rdata;
        rd_id_q   <= tag_id_q[RD_LAT-1];
      end
    end
  end

  assign bus.fifo_r_en = issue;
  assign bus.busy      = (state_q != IDLE);
  assign bus.gnt       = gnt_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_id     = rd_id_q;

endmodule
